// File: rtl/panda_pkg.sv
// ============================================================================
// Module   : panda_pkg
// Purpose  : Shared types for the Panda pipeline MEM stage and its LSU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package panda_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RD_DATA_ALU    = 2'd0,
        RD_DATA_PC_INC = 2'd1,
        RD_DATA_IMM    = 2'd2,
        RD_DATA_LSU    = 2'd3
    } rd_data_sel_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_width_e;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] pc_inc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs2_data;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic            rd_we;
        rd_data_sel_e    rd_data_sel;
        logic            lsu_store;
        lsu_width_e      lsu_width;
        logic            lsu_load_unsigned;
    } ex_mem_t;

    typedef struct packed {
        logic [4:0]      rd_addr;
        logic            rd_we;
        logic [XLEN-1:0] rd_data;
    } mem_wb_t;

endpackage

`default_nettype wire

// File: rtl/panda_lsu_align.sv
// ============================================================================
// Module   : panda_lsu_align
// Purpose  : Combinational byte-lane alignment for stores and loads.
//            Macro PANDA_LSU_MISALIGNED_TRAP_EN selects flag-vs-force-align.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module panda_lsu_align
    import panda_pkg::*;
(
    input  logic [1:0]      off,
    input  lsu_width_e      width,
    input  logic            load_unsigned,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] rdata,
    output logic [1:0]      eff_off,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned
);

    logic [XLEN-1:0] shifted;

`ifdef PANDA_LSU_MISALIGNED_TRAP_EN
    assign eff_off    = off;
    assign misaligned = ((width == HALF) && off[0]) ||
                        ((width == WORD) && (off != 2'b00));
`else
    // Unaligned halves/words silently drop the low address bits.
    always_comb begin
        eff_off = off;
        case (width)
            HALF:    eff_off = {off[1], 1'b0};
            WORD:    eff_off = 2'b00;
            default: eff_off = off;
        endcase
    end
    assign misaligned = 1'b0;
`endif

    assign shifted = rdata >> {eff_off, 3'b000};

    always_comb begin
        be        = 4'b1111;
        wdata     = rs2;
        load_data = shifted;
        case (width)
            BYTE: begin
                be        = 4'b0001 << eff_off;
                wdata     = {4{rs2[7:0]}};
                load_data = {{24{~load_unsigned & shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                be        = 4'b0011 << eff_off;
                wdata     = {2{rs2[15:0]}};
                load_data = {{16{~load_unsigned & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                be        = 4'b1111;
                wdata     = rs2;
                load_data = shifted;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/panda_mem_stage.sv
// ============================================================================
// Module   : panda_mem_stage
// Purpose  : Panda MEM stage - LSU req/gnt/rvalid FSM and MEM/WB register.
//            Macro PANDA_LSU_MISALIGNED_TRAP_EN enables misaligned dropping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module panda_mem_stage
    import panda_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  ex_mem_t         ex_mem_i,
    output mem_wb_t         mem_wb_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            stall_o,
    output logic            data_req_o,
    input  logic            data_gnt_i,
    input  logic            data_rvalid_i,
    output logic [XLEN-1:0] data_addr_o,
    output logic            data_we_o,
    output logic [3:0]      data_be_o,
    output logic [XLEN-1:0] data_wdata_o,
    input  logic [XLEN-1:0] data_rdata_i,
    output logic            misaligned_o
);

    lsu_state_e      state, state_next;
    mem_wb_t         mem_wb_q, mem_wb_d;
    logic [XLEN-1:0] wdata_hold;
    logic            orphan_ok;

    logic            mem_op, issue_op, complete, misaligned;
    logic [1:0]      eff_off;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata, load_data, rs2_fwd;

    assign mem_op = ex_mem_i.lsu_store || (ex_mem_i.rd_data_sel == RD_DATA_LSU);

    // A store right behind a load of its source register sees the loaded word.
    assign rs2_fwd = (mem_wb_q.rd_we && (ex_mem_i.rs2_addr != 5'd0) &&
                      (ex_mem_i.rs2_addr == mem_wb_q.rd_addr)) ?
                     mem_wb_q.rd_data : ex_mem_i.rs2_data;

    panda_lsu_align u_align (
        .off           (ex_mem_i.alu_result[1:0]),
        .width         (ex_mem_i.lsu_width),
        .load_unsigned (ex_mem_i.lsu_load_unsigned),
        .rs2           (rs2_fwd),
        .rdata         (data_rdata_i),
        .eff_off       (eff_off),
        .be            (be),
        .wdata         (wdata),
        .load_data     (load_data),
        .misaligned    (misaligned)
    );

    assign issue_op = mem_op && !misaligned;
    assign complete = (state == WAIT_RVALID) && data_rvalid_i;
    assign stall_o  = issue_op && !complete;

    always_comb begin
        state_next = state;
        data_req_o = 1'b0;
        case (state)
            IDLE: begin
                if (issue_op) begin
                    data_req_o = 1'b1;
                    state_next = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                data_req_o = 1'b1;
                if (data_gnt_i) begin
                    state_next = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign data_addr_o  = {ex_mem_i.alu_result[XLEN-1:2], eff_off};
    assign data_we_o    = ex_mem_i.lsu_store;
    assign data_be_o    = be;
    // Forwarded source vanishes once the stall bubbles MEM/WB; replay the latched copy.
    assign data_wdata_o = (state == WAIT_GNT) ? wdata_hold : wdata;

    always_comb begin
        mem_wb_d = '0;
        if (!mem_op) begin
            mem_wb_d.rd_addr = ex_mem_i.rd_addr;
            mem_wb_d.rd_we   = ex_mem_i.rd_we;
            case (ex_mem_i.rd_data_sel)
                RD_DATA_PC_INC: mem_wb_d.rd_data = ex_mem_i.pc_inc;
                RD_DATA_IMM:    mem_wb_d.rd_data = ex_mem_i.imm;
                default:        mem_wb_d.rd_data = ex_mem_i.alu_result;
            endcase
        end else if (complete) begin
            mem_wb_d.rd_addr = ex_mem_i.rd_addr;
            if (!ex_mem_i.lsu_store) begin
                mem_wb_d.rd_we   = ex_mem_i.rd_we;
                mem_wb_d.rd_data = load_data;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            mem_wb_q   <= '0;
            wdata_hold <= '0;
            orphan_ok  <= 1'b1;
        end else begin
            state    <= state_next;
            mem_wb_q <= mem_wb_d;
            if ((state == IDLE) && data_req_o) begin
                wdata_hold <= wdata;
            end
            if (data_req_o) begin
                orphan_ok <= 1'b0;
            end
        end
    end

    assign mem_wb_o  = mem_wb_q;
    assign rd_addr_o = mem_wb_q.rd_addr;
    assign rd_we_o   = mem_wb_q.rd_we;
    assign rd_data_o = mem_wb_q.rd_data;

`ifdef PANDA_LSU_MISALIGNED_TRAP_EN
    assign misaligned_o = mem_op && misaligned && (state == IDLE);
`else
    assign misaligned_o = 1'b0;
`endif

    // Responses only belong in WAIT_RVALID, except one cut off by a reset.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(data_rvalid_i && (state != WAIT_RVALID) && !orphan_ok));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_panda_mem_stage.sv
// ============================================================================
// Module   : tb_panda_mem_stage
// Purpose  : Directed self-checking bench for panda_mem_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_panda_mem_stage;
    import panda_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    ex_mem_t     ex;
    mem_wb_t     mem_wb;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [31:0] rd_data;
    logic        stall, req, gnt, rvalid, we, misaligned;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    panda_mem_stage dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .ex_mem_i      (ex),
        .mem_wb_o      (mem_wb),
        .rd_addr_o     (rd_addr),
        .rd_we_o       (rd_we),
        .rd_data_o     (rd_data),
        .stall_o       (stall),
        .data_req_o    (req),
        .data_gnt_i    (gnt),
        .data_rvalid_i (rvalid),
        .data_addr_o   (addr),
        .data_we_o     (we),
        .data_be_o     (be),
        .data_wdata_o  (wdata),
        .data_rdata_i  (rdata),
        .misaligned_o  (misaligned)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic mem_wb_t wb(input logic [4:0] a, input logic w, input logic [31:0] d);
        mem_wb_t r;
        r.rd_addr = a;
        r.rd_we   = w;
        r.rd_data = d;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ex = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        tick; tick;
        chk("reset_mem_wb", mem_wb, 38'd0);
        chk("reset_stall", stall, 1'b0);
        chk("reset_req", req, 1'b0);
        chk("reset_misaligned", misaligned, 1'b0);
        rst_n = 1'b1;

        // ALU / PC_INC / IMM writeback
        ex.rd_data_sel = RD_DATA_ALU; ex.alu_result = 32'h1234; ex.rd_addr = 5'd5; ex.rd_we = 1'b1;
        mid;
        chk("alu_stall", stall, 1'b0);
        chk("alu_req", req, 1'b0);
        tick;
        chk("alu_wb", mem_wb, wb(5'd5, 1'b1, 32'h1234));
        chk("alu_fwd_addr", rd_addr, 5'd5);
        chk("alu_fwd_data", rd_data, 32'h1234);
        ex.rd_data_sel = RD_DATA_PC_INC; ex.pc_inc = 32'h88; ex.rd_addr = 5'd6;
        tick;
        chk("pcinc_wb", mem_wb, wb(5'd6, 1'b1, 32'h88));
        ex.rd_data_sel = RD_DATA_IMM; ex.imm = 32'hFFFF_F000; ex.rd_addr = 5'd0;
        tick;
        chk("imm_x0_wb", mem_wb, wb(5'd0, 1'b1, 32'hFFFF_F000));

        // LB signed at offset 3, gnt immediate, rvalid next cycle
        ex = '0; ex.rd_data_sel = RD_DATA_LSU; ex.lsu_width = BYTE; ex.alu_result = 32'h103;
        ex.rd_addr = 5'd3; ex.rd_we = 1'b1; gnt = 1'b1;
        mid;
        chk("lb_req", req, 1'b1);
        chk("lb_be", be, 4'b1000);
        chk("lb_addr", addr, 32'h103);
        chk("lb_we", we, 1'b0);
        chk("lb_stall0", stall, 1'b1);
        tick;
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h8000_0000;
        mid;
        chk("lb_stall1", stall, 1'b0);
        chk("lb_req1", req, 1'b0);
        tick;
        chk("lb_wb", mem_wb, wb(5'd3, 1'b1, 32'hFFFF_FF80));
        rvalid = 1'b0; ex = '0;

        // SH at offset 2 with gnt delayed 3 cycles
        ex.lsu_store = 1'b1; ex.lsu_width = HALF; ex.alu_result = 32'h202;
        ex.rs2_data = 32'hAAAA_BEEF; ex.rs2_addr = 5'd9;
        for (int i = 0; i < 4; i++) begin
            gnt = (i == 3);
            mid;
            chk($sformatf("sh_req_c%0d", i), req, 1'b1);
            chk($sformatf("sh_addr_c%0d", i), addr, 32'h202);
            chk($sformatf("sh_be_c%0d", i), be, 4'b1100);
            chk($sformatf("sh_wdata_c%0d", i), wdata, 32'hBEEF_BEEF);
            chk($sformatf("sh_stall_c%0d", i), stall, 1'b1);
            tick;
        end
        gnt = 1'b0; rvalid = 1'b1;
        mid;
        chk("sh_done_req", req, 1'b0);
        chk("sh_done_stall", stall, 1'b0);
        tick;
        chk("sh_rd_we", rd_we, 1'b0);
        rvalid = 1'b0; ex = '0;

        // LW x7 then back-to-back SW with rs2=x7, store gnt delayed 1 cycle
        ex.rd_data_sel = RD_DATA_LSU; ex.lsu_width = WORD; ex.alu_result = 32'h40;
        ex.rd_addr = 5'd7; ex.rd_we = 1'b1; gnt = 1'b1;
        tick;
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        tick;
        chk("lw7_wb", mem_wb, wb(5'd7, 1'b1, 32'hCAFE_F00D));
        rvalid = 1'b0;
        ex = '0; ex.lsu_store = 1'b1; ex.lsu_width = WORD; ex.alu_result = 32'h44;
        ex.rs2_data = 32'h1111_1111; ex.rs2_addr = 5'd7;
        mid;
        chk("sw_fwd_req", req, 1'b1);
        chk("sw_fwd_we", we, 1'b1);
        chk("sw_fwd_wdata", wdata, 32'hCAFE_F00D);
        tick;
        gnt = 1'b1;
        mid;
        chk("sw_hold_wdata", wdata, 32'hCAFE_F00D);
        chk("sw_stall_bubble", rd_we, 1'b0);
        tick;
        gnt = 1'b0; rvalid = 1'b1;
        tick;
        rvalid = 1'b0; ex = '0;

        // LW at misaligned address 0x102
        ex.rd_data_sel = RD_DATA_LSU; ex.lsu_width = WORD; ex.alu_result = 32'h102;
        ex.rd_addr = 5'd8; ex.rd_we = 1'b1;
`ifdef PANDA_LSU_MISALIGNED_TRAP_EN
        gnt = 1'b0;
        mid;
        chk("mis_req", req, 1'b0);
        chk("mis_stall", stall, 1'b0);
        chk("mis_pulse", misaligned, 1'b1);
        tick;
        chk("mis_bubble", mem_wb, 38'd0);
        ex = '0;
        mid;
        chk("mis_pulse_end", misaligned, 1'b0);
`else
        gnt = 1'b1;
        mid;
        chk("mis_req", req, 1'b1);
        chk("mis_addr", addr, 32'h100);
        chk("mis_be", be, 4'b1111);
        chk("mis_flag", misaligned, 1'b0);
        tick;
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0123_4567;
        tick;
        chk("mis_wb", mem_wb, wb(5'd8, 1'b1, 32'h0123_4567));
        rvalid = 1'b0; ex = '0;
`endif

        // Reset while waiting for rvalid, stale rvalid after release
        ex = '0; ex.rd_data_sel = RD_DATA_LSU; ex.lsu_width = WORD; ex.alu_result = 32'h80;
        ex.rd_addr = 5'd4; ex.rd_we = 1'b1; gnt = 1'b1;
        tick;
        gnt = 1'b0;
        mid;
        chk("rst_pre_stall", stall, 1'b1);
        rst_n = 1'b0; ex = '0;
        #1;
        chk("rst_mid_stall", stall, 1'b0);
        chk("rst_mid_req", req, 1'b0);
        chk("rst_mid_wb", mem_wb, 38'd0);
        tick;
        rst_n = 1'b1;
        ex.rd_data_sel = RD_DATA_ALU; ex.alu_result = 32'h55; ex.rd_addr = 5'd2; ex.rd_we = 1'b1;
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        mid;
        chk("late_rvalid_stall", stall, 1'b0);
        chk("late_rvalid_req", req, 1'b0);
        tick;
        chk("late_rvalid_wb", mem_wb, wb(5'd2, 1'b1, 32'h55));
        rvalid = 1'b0;

        // LBU at offset 1 after reset recovery
        ex = '0; ex.rd_data_sel = RD_DATA_LSU; ex.lsu_width = BYTE; ex.lsu_load_unsigned = 1'b1;
        ex.alu_result = 32'h101; ex.rd_addr = 5'd3; ex.rd_we = 1'b1; gnt = 1'b1;
        mid;
        chk("lbu_req", req, 1'b1);
        chk("lbu_be", be, 4'b0010);
        chk("lbu_stall", stall, 1'b1);
        tick;
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_AB00;
        tick;
        chk("lbu_wb", mem_wb, wb(5'd3, 1'b1, 32'h0000_00AB));
        rvalid = 1'b0; ex = '0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
